// File: rtl/ad_sample_sequencer_if.sv
// Sample stream from the ADC sequencer to the capture FIFO.
// Ports: m_data/m_valid/m_last (source), m_ready (sink); transfer on m_valid & m_ready.
interface ad_sample_sequencer_if #(
  parameter int ADC_W = 12
) ();
  logic [ADC_W-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic             m_last;

  modport master (
    output m_data,
    output m_valid,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/ad_sample_sequencer.sv
// Runs one burst of i_ad_cnt paced CONVST/BUSY conversions per start pulse and streams
// samples out through a single-entry output register.
// Ports: clk, reset_n (async, active-low); i_ad_cnt, i_start, i_abort (CPU control);
// o_adc_convst, i_adc_busy, i_adc_data (ADC); m_if (sample stream, master);
// o_busy, o_done, o_overrun, o_timeout_err, o_samples_taken (status).
module ad_sample_sequencer #(
  parameter int ADC_W         = 12,
  parameter int SAMPLE_PERIOD = 50,
  parameter int BUSY_GUARD    = 2,
  parameter int TIMEOUT       = 255
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [15:0]            i_ad_cnt,
  input  logic                   i_start,
  input  logic                   i_abort,
  output logic                   o_adc_convst,
  input  logic                   i_adc_busy,
  input  logic [ADC_W-1:0]       i_adc_data,
  ad_sample_sequencer_if.master  m_if,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_overrun,
  output logic                   o_timeout_err,
  output logic [15:0]            o_samples_taken
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV,
    S_WAIT,
    S_PACE,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [15:0]      r_target;
  logic [15:0]      r_samples;
  logic [15:0]      r_period;
  logic [15:0]      r_wait;
  logic             r_convst;
  logic             r_busy;
  logic             r_done;
  logic             r_overrun;
  logic             r_timeout;
  logic [ADC_W-1:0] r_data;
  logic             r_valid;
  logic             r_last;

  logic [15:0] w_wait_nxt;
  logic [15:0] w_period_nxt;
  logic [15:0] w_samples_nxt;
  logic        w_latch;
  logic        w_final;
  logic        w_room;

  assign w_wait_nxt    = r_wait + 16'd1;
  assign w_period_nxt  = (r_period == 16'd0) ? 16'd0 : r_period - 16'd1;
  assign w_samples_nxt = r_samples + 16'd1;
  // The guard is judged on the post-increment count so that a quiet ADC
  // yields m_valid BUSY_GUARD+1 cycles after convst.
  assign w_latch = (r_state == S_WAIT) && !i_abort && !i_adc_busy &&
                   (w_wait_nxt >= 16'(BUSY_GUARD));
  assign w_final = (w_samples_nxt == r_target);
  assign w_room  = !r_valid || m_if.m_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_target  <= '0;
      r_samples <= '0;
      r_period  <= '0;
      r_wait    <= '0;
      r_convst  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
      r_timeout <= 1'b0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
    end else begin
      r_convst <= 1'b0;
      r_done   <= 1'b0;

      if (r_state != S_CONV)
        r_period <= w_period_nxt;

      if (w_latch && w_room) begin
        r_data  <= i_adc_data;
        r_valid <= 1'b1;
        r_last  <= w_final;
      end else if (r_valid && m_if.m_ready) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end
      if (w_latch && !w_room)
        r_overrun <= 1'b1;

      if (i_abort && (r_state != S_IDLE)) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (i_start && !i_abort) begin
              r_samples <= '0;
              r_overrun <= 1'b0;
              r_timeout <= 1'b0;
              r_busy    <= 1'b1;
              if (i_ad_cnt != 16'd0) begin
                r_target <= i_ad_cnt;
                r_convst <= 1'b1;
                r_state  <= S_CONV;
              end else begin
                r_state <= S_DONE;
              end
            end
          end
          S_CONV: begin
            r_period <= 16'(SAMPLE_PERIOD - 1);
            r_wait   <= '0;
            r_state  <= S_WAIT;
          end
          S_WAIT: begin
            r_wait <= w_wait_nxt;
            if (w_latch) begin
              r_samples <= w_samples_nxt;
              r_state   <= w_final ? S_DONE : S_PACE;
            end else if (w_wait_nxt == 16'(TIMEOUT)) begin
              r_timeout <= 1'b1;
              r_state   <= S_DONE;
            end
          end
          S_PACE: begin
            // Leaving on the cycle the counter hits 0 keeps
            // convst edges exactly SAMPLE_PERIOD apart.
            if (w_period_nxt == 16'd0) begin
              r_convst <= 1'b1;
              r_state  <= S_CONV;
            end
          end
          S_DONE: begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_adc_convst    = r_convst;
  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_overrun       = r_overrun;
  assign o_timeout_err   = r_timeout;
  assign o_samples_taken = r_samples;
  assign m_if.m_data     = r_data;
  assign m_if.m_valid    = r_valid;
  assign m_if.m_last     = r_last;

endmodule

// File: tb/tb_ad_sample_sequencer.sv
// Bench for ad_sample_sequencer: table of bursts plus reset/latency sequences.
// ADC model raises busy for busy_len cycles after each convst; data = 0x100 + conversion index.
module tb_ad_sample_sequencer;
  localparam int ADC_W = 12;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0]      ad_cnt = '0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             adc_busy;
  logic [ADC_W-1:0] adc_data;
  logic             convst, busy, done, ovr, tout;
  logic [15:0]      samples;

  ad_sample_sequencer_if #(.ADC_W(ADC_W)) s_if ();

  ad_sample_sequencer dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .i_ad_cnt        (ad_cnt),
    .i_start         (start),
    .i_abort         (abort),
    .o_adc_convst    (convst),
    .i_adc_busy      (adc_busy),
    .i_adc_data      (adc_data),
    .m_if            (s_if),
    .o_busy          (busy),
    .o_done          (done),
    .o_overrun       (ovr),
    .o_timeout_err   (tout),
    .o_samples_taken (samples)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic clr = 1'b0;
  int cyc = 0;
  int n_conv, n_xfer, n_done, n_busy, last_idx, start_t, done_t, first_v;
  int conv_t [0:15];
  logic [ADC_W-1:0] xd [0:15];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (clr) begin
      n_conv   <= 0;
      n_xfer   <= 0;
      n_done   <= 0;
      n_busy   <= 0;
      last_idx <= -1;
      start_t  <= -1;
      done_t   <= -1;
      first_v  <= -1;
    end else begin
      if (convst) begin
        if (n_conv < 16) conv_t[n_conv] <= cyc;
        n_conv <= n_conv + 1;
      end
      if (s_if.m_valid && s_if.m_ready) begin
        if (n_xfer < 16) xd[n_xfer] <= s_if.m_data;
        if (s_if.m_last) last_idx <= n_xfer;
        n_xfer <= n_xfer + 1;
      end
      if (done) begin
        n_done <= n_done + 1;
        done_t <= cyc;
      end
      if (busy) n_busy <= n_busy + 1;
      if (start && start_t < 0) start_t <= cyc;
      if (s_if.m_valid && first_v < 0) first_v <= cyc;
    end
  end

  int busy_len = 10;
  logic stuck = 1'b0;
  int bcnt;
  logic [ADC_W-1:0] dq;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bcnt <= 0;
      dq   <= '0;
    end else if (convst) begin
      bcnt <= busy_len;
      dq   <= ADC_W'(12'h100 + n_conv);
    end else if (bcnt != 0) begin
      bcnt <= bcnt - 1;
    end
  end
  assign adc_busy = stuck | (bcnt != 0);
  assign adc_data = dq;

  typedef struct {
    int cnt; bit rdy; bit stk; int abort_at; int blen;
    int e_conv; int e_xfer; int e_samp; int e_ovr; int e_to; int e_done;
    int e_last; int e_gap; int e_busyc; int e_lat; int e_d0;
  } vec_t;

  vec_t vt [0:6];

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic run_vec(input int id, input vec_t v);
    bit ok;
    bit aborted;
    stuck = v.stk;
    busy_len = v.blen;
    s_if.m_ready = v.rdy;
    repeat (3) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    ad_cnt = 16'(v.cnt);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ad_cnt = 16'd7;
    ok = 1'b0;
    aborted = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (v.abort_at > 0 && !aborted && samples == 16'(v.abort_at)) begin
        abort = 1'b1;
        aborted = 1'b1;
      end else begin
        abort = 1'b0;
      end
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    abort = 1'b0;
    repeat (3) @(negedge clk);
    chk($sformatf("v%0d_end", id), int'(ok), 1);
    chk($sformatf("v%0d_conv", id), n_conv, v.e_conv);
    chk($sformatf("v%0d_xfer", id), n_xfer, v.e_xfer);
    chk($sformatf("v%0d_samples", id), int'(samples), v.e_samp);
    chk($sformatf("v%0d_overrun", id), int'(ovr), v.e_ovr);
    chk($sformatf("v%0d_timeout", id), int'(tout), v.e_to);
    chk($sformatf("v%0d_done", id), n_done, v.e_done);
    chk($sformatf("v%0d_busy", id), int'(busy), 0);
    chk($sformatf("v%0d_last", id), last_idx, v.e_last);
    if (v.e_gap >= 0)
      chk($sformatf("v%0d_done_gap", id), done_t - start_t, v.e_gap);
    if (v.e_busyc >= 0)
      chk($sformatf("v%0d_busy_cyc", id), n_busy, v.e_busyc);
    if (v.e_lat >= 0)
      chk($sformatf("v%0d_latency", id), first_v - conv_t[0], v.e_lat);
    for (int i = 0; i + 1 < n_conv && i < 15; i++)
      chk($sformatf("v%0d_period%0d", id, i), conv_t[i+1] - conv_t[i], 50);
    if (v.e_d0 >= 0) begin
      if (v.rdy) begin
        chk($sformatf("v%0d_data0", id), int'(xd[0]), v.e_d0);
        for (int i = 1; i < n_xfer && i < 16; i++)
          chk($sformatf("v%0d_data%0d", id, i), int'(xd[i]), v.e_d0 + i);
      end else begin
        chk($sformatf("v%0d_hold_valid", id), int'(s_if.m_valid), 1);
        chk($sformatf("v%0d_hold_data", id), int'(s_if.m_data), v.e_d0);
        chk($sformatf("v%0d_hold_last", id), int'(s_if.m_last), 0);
      end
    end
  endtask

  initial begin
    bit seen;
    //        cnt rdy stk ab blen conv xfer samp ovr to done last gap busyc lat d0
    vt[0] = '{4,  1, 0, 0, 10,  4,   4,   4,   0,  0, 1,   3,  164, 163,  12, 'h100};
    vt[1] = '{0,  1, 0, 0, 10,  0,   0,   0,   0,  0, 1,  -1,    2,   1,  -1, -1};
    vt[2] = '{3,  0, 0, 0, 10,  3,   0,   3,   1,  0, 1,  -1,  114, 113,  12, 'h100};
    vt[3] = '{5,  1, 1, 0, 10,  1,   0,   0,   0,  1, 1,  -1,  258, 257,  -1, -1};
    vt[4] = '{10, 1, 0, 3, 10,  3,   3,   3,   0,  0, 0,  -1,   -1,  -1,  12, 'h100};
    vt[5] = '{2,  1, 0, 0, 0,   2,   2,   2,   0,  0, 1,   1,   55,  54,   3, 'h100};
    vt[6] = '{2,  1, 0, 0, 10,  2,   2,   2,   0,  0, 1,   1,   64,  63,  12, 'h100};

    s_if.m_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_convst", int'(convst), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(s_if.m_valid), 0);
    chk("rst_samples", int'(samples), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++)
      run_vec(i, vt[i]);

    // Reset while the second conversion of a burst is in WAIT, sample pending.
    busy_len = 10;
    stuck = 1'b0;
    s_if.m_ready = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    ad_cnt = 16'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (n_conv == 2) begin
        seen = 1'b1;
        break;
      end
    end
    chk("mid_second_conv", int'(seen), 1);
    repeat (4) @(negedge clk);
    chk("mid_pre_valid", int'(s_if.m_valid), 1);
    chk("mid_pre_samples", int'(samples), 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_valid", int'(s_if.m_valid), 0);
    chk("mid_rst_data", int'(s_if.m_data), 0);
    chk("mid_rst_last", int'(s_if.m_last), 0);
    chk("mid_rst_samples", int'(samples), 0);
    chk("mid_rst_convst", int'(convst), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_flags", int'({ovr, tout}), 0);
    @(negedge clk);
    reset_n = 1'b1;
    run_vec(6, vt[6]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
